// File: rtl/uart_core.sv
// UART core: oversampled transmitter and receiver with a synchronous active-low reset.
// Defining UART_PARITY_EN adds an even-parity bit after the data bits in both directions.
module uart_core #(
    parameter int BYTESIZES           = 8,
    parameter int OVERSAMPLING        = 16,
    parameter int BAUDRATE            = 9600,
    parameter int COUNTER_CLOCK_INPUT = 50_000_000
) (
    input  logic                 clock,
    input  logic                 nreset,
    input  logic                 valid_tx_in,
    input  logic [BYTESIZES-1:0] data_tx_in,
    output logic                 ready_tx_out,
    output logic                 sdata_tx_out,
    input  logic                 sdata_rx_in,
    input  logic                 valid_rx_in,
    output logic                 ready_rx_out,
    output logic [BYTESIZES+3:0] data_rx_out
);

`ifdef UART_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    localparam int DIV_RAW = COUNTER_CLOCK_INPUT / (BAUDRATE * OVERSAMPLING);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W    = (OVERSAMPLING > 1) ? $clog2(OVERSAMPLING) : 1;
    localparam int BIT_W   = (BYTESIZES > 1) ? $clog2(BYTESIZES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLING - 1);
    localparam logic [OS_W-1:0]  HALF_LAST = OS_W'(OVERSAMPLING / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(BYTESIZES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    state_t               tx_state;
    state_t               tx_state_next;
    logic                 tx_accept;
    logic [DIV_W-1:0]     tx_div_cnt;
    logic [OS_W-1:0]      tx_os_cnt;
    logic [BIT_W-1:0]     tx_bit_cnt;
    logic [BYTESIZES-1:0] tx_shift;
    logic                 tx_parity;
    logic                 tx_tick;
    logic                 tx_bit_end;

    assign tx_tick    = (tx_div_cnt == DIV_LAST);
    assign tx_bit_end = tx_tick && (tx_os_cnt == OS_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            tx_state <= IDLE;
        end else begin
            tx_state <= tx_state_next;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        tx_state_next = tx_state;
        tx_accept     = 1'b0;
        ready_tx_out  = 1'b0;
        sdata_tx_out  = 1'b1;
        case (tx_state)
            IDLE: begin
                ready_tx_out = 1'b1;
                if (valid_tx_in) begin
                    tx_accept     = 1'b1;
                    tx_state_next = START;
                end
            end
            START: begin
                sdata_tx_out = 1'b0;
                if (tx_bit_end) tx_state_next = DATA;
            end
            DATA: begin
                sdata_tx_out = tx_shift[0];
                if (tx_bit_end && (tx_bit_cnt == BIT_LAST)) begin
                    tx_state_next = PARITY_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                sdata_tx_out = tx_parity;
                if (tx_bit_end) tx_state_next = STOP;
            end
            STOP: begin
                if (tx_bit_end) tx_state_next = IDLE;
            end
            default: tx_state_next = IDLE;
        endcase
    end

    // Bit timing restarts on every accept so each frame gets exact bit periods.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            tx_div_cnt <= '0;
            tx_os_cnt  <= '0;
            tx_bit_cnt <= '0;
            tx_shift   <= '0;
            tx_parity  <= 1'b0;
        end else if (tx_accept) begin
            tx_div_cnt <= '0;
            tx_os_cnt  <= '0;
            tx_bit_cnt <= '0;
            tx_shift   <= data_tx_in;
            tx_parity  <= ^data_tx_in;
        end else if (tx_state != IDLE) begin
            tx_div_cnt <= tx_tick ? '0 : tx_div_cnt + 1'b1;
            if (tx_tick) begin
                tx_os_cnt <= (tx_os_cnt == OS_LAST) ? '0 : tx_os_cnt + 1'b1;
            end
            if (tx_bit_end && (tx_state == DATA)) begin
                tx_shift   <= {1'b0, tx_shift[BYTESIZES-1:1]};
                tx_bit_cnt <= tx_bit_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    state_t               rx_state;
    state_t               rx_state_next;
    logic [1:0]           rx_sync_q;
    logic                 rx_line;
    logic                 rx_prev;
    logic                 rx_start;
    logic                 rx_done;
    logic [DIV_W-1:0]     rx_div_cnt;
    logic [OS_W-1:0]      rx_os_cnt;
    logic [OS_W-1:0]      rx_limit;
    logic [BIT_W-1:0]     rx_bit_cnt;
    logic [BYTESIZES-1:0] rx_shift;
    logic                 rx_parity_bit;
    logic                 rx_tick;
    logic                 rx_sample;
    logic                 rx_frame_err;
    logic                 rx_parity_err;
    logic                 rx_overrun;
    logic                 rx_break;

    // Synchronizer resets to the idle line level so reset never looks like a start edge.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            rx_sync_q <= 2'b11;
            rx_prev   <= 1'b1;
        end else begin
            rx_sync_q <= {rx_sync_q[0], sdata_rx_in};
            rx_prev   <= rx_sync_q[1];
        end
    end

    assign rx_line   = rx_sync_q[1];
    assign rx_tick   = (rx_div_cnt == DIV_LAST);
    assign rx_limit  = (rx_state == START) ? HALF_LAST : OS_LAST;
    assign rx_sample = rx_tick && (rx_os_cnt == rx_limit);

    always_ff @(posedge clock) begin
        if (!nreset) begin
            rx_state <= IDLE;
        end else begin
            rx_state <= rx_state_next;
        end
    end

    // A start needs a 1->0 edge, so a line held low after a frame error cannot rearm.
    always_comb begin
        rx_state_next = rx_state;
        rx_start      = 1'b0;
        rx_done       = 1'b0;
        case (rx_state)
            IDLE: begin
                if (rx_prev && !rx_line) begin
                    rx_start      = 1'b1;
                    rx_state_next = START;
                end
            end
            START: begin
                if (rx_sample) rx_state_next = rx_line ? IDLE : DATA;
            end
            DATA: begin
                if (rx_sample && (rx_bit_cnt == BIT_LAST)) begin
                    rx_state_next = PARITY_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (rx_sample) rx_state_next = STOP;
            end
            STOP: begin
                if (rx_sample) begin
                    rx_done       = 1'b1;
                    rx_state_next = IDLE;
                end
            end
            default: rx_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            rx_div_cnt    <= '0;
            rx_os_cnt     <= '0;
            rx_bit_cnt    <= '0;
            rx_shift      <= '0;
            rx_parity_bit <= 1'b0;
        end else if (rx_start) begin
            rx_div_cnt <= '0;
            rx_os_cnt  <= '0;
            rx_bit_cnt <= '0;
        end else if (rx_state != IDLE) begin
            rx_div_cnt <= rx_tick ? '0 : rx_div_cnt + 1'b1;
            if (rx_tick) begin
                rx_os_cnt <= (rx_os_cnt == rx_limit) ? '0 : rx_os_cnt + 1'b1;
            end
            if (rx_sample && (rx_state == DATA)) begin
                rx_shift   <= {rx_line, rx_shift[BYTESIZES-1:1]};
                rx_bit_cnt <= rx_bit_cnt + 1'b1;
            end
            if (rx_sample && (rx_state == PARITY)) begin
                rx_parity_bit <= rx_line;
            end
        end
    end

    assign rx_frame_err  = ~rx_line;
    assign rx_parity_err = PARITY_EN & ((^rx_shift) ^ rx_parity_bit);
    assign rx_break      = rx_frame_err & (rx_shift == '0) & ~(PARITY_EN & rx_parity_bit);
    assign rx_overrun    = ready_rx_out & ~valid_rx_in;

    // A completing frame wins over an acknowledge in the same cycle.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            ready_rx_out <= 1'b0;
            data_rx_out  <= '0;
        end else if (rx_done) begin
            ready_rx_out <= 1'b1;
            data_rx_out  <= {rx_break, rx_overrun, rx_parity_err, rx_frame_err, rx_shift};
        end else if (valid_rx_in) begin
            ready_rx_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core at DIV=1 (1.6 MHz clock, 100 kbit/s, 16x oversampling).
`timescale 1ns/1ps
module tb_uart_core;
    localparam int B  = 8;
    localparam int OS = 16;
`ifdef UART_PARITY_EN
    localparam int NBITS = B + 3;
`else
    localparam int NBITS = B + 2;
`endif
    localparam int FRAME = NBITS * OS;

    logic         clock = 1'b0;
    logic         nreset;
    logic         valid_tx_in;
    logic [B-1:0] data_tx_in;
    logic         ready_tx_out;
    logic         sdata_tx_out;
    logic         sdata_rx_in;
    logic         valid_rx_in;
    logic         ready_rx_out;
    logic [B+3:0] data_rx_out;

    logic loop_en;
    logic rx_force;

    assign sdata_rx_in = loop_en ? sdata_tx_out : rx_force;

    always #5 clock = ~clock;

    uart_core #(
        .BYTESIZES          (B),
        .OVERSAMPLING       (OS),
        .BAUDRATE           (100_000),
        .COUNTER_CLOCK_INPUT(1_600_000)
    ) dut (
        .clock       (clock),
        .nreset      (nreset),
        .valid_tx_in (valid_tx_in),
        .data_tx_in  (data_tx_in),
        .ready_tx_out(ready_tx_out),
        .sdata_tx_out(sdata_tx_out),
        .sdata_rx_in (sdata_rx_in),
        .valid_rx_in (valid_rx_in),
        .ready_rx_out(ready_rx_out),
        .data_rx_out (data_rx_out)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [NBITS-1:0] frame_bits(input logic [B-1:0] d, input logic stop_bit);
        logic [NBITS-1:0] f;
        f      = '0;
        f[B:1] = d;
`ifdef UART_PARITY_EN
        f[B+1] = ^d;
`endif
        f[NBITS-1] = stop_bit;
        return f;
    endfunction

    task automatic send_rx(input logic [B-1:0] d, input logic stop_bit);
        logic [NBITS-1:0] f;
        f = frame_bits(d, stop_bit);
        for (int b = 0; b < NBITS; b++) begin
            rx_force = f[b];
            repeat (OS) tick();
        end
        rx_force = 1'b1;
        repeat (8) tick();
    endtask

    task automatic ack_rx(input string tag);
        valid_rx_in = 1'b1;
        tick();
        valid_rx_in = 1'b0;
        check(tag, ready_rx_out, 1'b0);
    endtask

    logic [NBITS-1:0] f;
    logic [OS-1:0]    seg;
    logic [B+3:0]     words[4];
    int               busy;
    int               n_acc;
    int               n_words;
    int               first_c;
    int               second_c;
    logic             acc;
    logic             seen_rdy;
    logic             seen_low;

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        nreset      = 1'b0;
        valid_tx_in = 1'b0;
        data_tx_in  = '0;
        valid_rx_in = 1'b0;
        loop_en     = 1'b0;
        rx_force    = 1'b1;
        repeat (3) tick();
        check("rst_sdata_tx", sdata_tx_out, 1'b1);
        check("rst_ready_tx", ready_tx_out, 1'b1);
        check("rst_ready_rx", ready_rx_out, 1'b0);
        check("rst_data_rx", data_rx_out, 12'h000);
        nreset = 1'b1;
        tick();

        // Loopback single frame, line checked one bit period at a time.
        loop_en     = 1'b1;
        data_tx_in  = 8'h78;
        valid_tx_in = 1'b1;
        tick();
        valid_tx_in = 1'b0;
        f    = frame_bits(8'h78, 1'b1);
        busy = 0;
        for (int b = 0; b < NBITS; b++) begin
            for (int s = 0; s < OS; s++) begin
                seg[s] = sdata_tx_out;
                if (!ready_tx_out) busy++;
                tick();
            end
            check("tx_bit", {16'h0, seg}, f[b] ? 32'h0000_FFFF : 32'h0);
        end
        check("tx_busy_clocks", busy, FRAME);
        check("tx_ready_back", ready_tx_out, 1'b1);
        check("lb_ready_rx", ready_rx_out, 1'b1);
        check("lb_data_rx", data_rx_out, 12'h078);
        ack_rx("lb_ack");

        // Back-to-back frames; data changes after the first accept must be ignored.
        data_tx_in  = 8'hA5;
        valid_tx_in = 1'b1;
        valid_rx_in = 1'b1;
        n_acc    = 0;
        n_words  = 0;
        first_c  = -1;
        second_c = -1;
        for (int c = 0; c < 2 * FRAME + 60; c++) begin
            if (ready_rx_out && n_words < 4) begin
                words[n_words] = data_rx_out;
                n_words++;
            end
            acc = valid_tx_in && ready_tx_out;
            tick();
            if (acc) begin
                n_acc++;
                if (n_acc == 1) begin
                    first_c    = c;
                    data_tx_in = 8'h3C;
                end else begin
                    second_c    = c;
                    valid_tx_in = 1'b0;
                end
            end
        end
        valid_rx_in = 1'b0;
        check("btb_accepts", n_acc, 2);
        check("btb_gap", second_c - first_c, FRAME + 1);
        check("btb_words", n_words, 2);
        check("btb_word0", words[0], 12'h0A5);
        check("btb_word1", words[1], 12'h03C);

        // Directly driven receive line.
        loop_en = 1'b0;
        repeat (4) tick();
        send_rx(8'h55, 1'b0);
        check("ferr_ready", ready_rx_out, 1'b1);
        check("ferr_data", data_rx_out, 12'h155);
        ack_rx("ferr_ack");
        repeat (20) tick();
        send_rx(8'h00, 1'b0);
        check("brk_data", data_rx_out, 12'h900);
        ack_rx("brk_ack");
        repeat (20) tick();

        send_rx(8'h12, 1'b1);
        check("ovr_first", data_rx_out, 12'h012);
        send_rx(8'h34, 1'b1);
        check("ovr_ready", ready_rx_out, 1'b1);
        check("ovr_second", data_rx_out, 12'h434);
        ack_rx("ovr_ack");

        // Short start glitch must not produce a word.
        rx_force = 1'b0;
        repeat (4) tick();
        rx_force = 1'b1;
        seen_rdy = 1'b0;
        repeat (40) begin
            if (ready_rx_out) seen_rdy = 1'b1;
            tick();
        end
        check("glitch_no_word", seen_rdy, 1'b0);

        // Reset in the middle of a loopback frame.
        loop_en     = 1'b1;
        data_tx_in  = 8'h5A;
        valid_tx_in = 1'b1;
        tick();
        valid_tx_in = 1'b0;
        repeat (60) tick();
        nreset = 1'b0;
        tick();
        check("midrst_sdata_tx", sdata_tx_out, 1'b1);
        check("midrst_ready_tx", ready_tx_out, 1'b1);
        check("midrst_data_rx", data_rx_out, 12'h000);
        repeat (2) tick();
        nreset   = 1'b1;
        seen_rdy = 1'b0;
        seen_low = 1'b0;
        repeat (FRAME + 40) begin
            if (ready_rx_out) seen_rdy = 1'b1;
            if (!sdata_tx_out) seen_low = 1'b1;
            tick();
        end
        check("midrst_no_word", seen_rdy, 1'b0);
        check("midrst_line_idle", seen_low, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_core.md
UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 SHALL have parameter BYTESIZES, default 8: data bits per frame.
REQ-002 SHALL have parameter OVERSAMPLING, default 16: receive samples per bit.
REQ-003 SHALL have parameter BAUDRATE, default 9600: line bit rate in bit/s.
REQ-004 SHALL have parameter COUNTER_CLOCK_INPUT, default 50_000_000: clock frequency in Hz.
REQ-005 SHALL have port clock  input  1  system clock, all logic on rising edge.
REQ-006 SHALL have port nreset  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port valid_tx_in  input  1  transmit request.
REQ-008 SHALL have port data_tx_in  input  BYTESIZES  byte to transmit.
REQ-009 SHALL have port ready_tx_out  output  1  transmitter idle, can accept.
REQ-010 SHALL have port sdata_tx_out  output  1  serial transmit line.
REQ-011 SHALL have port sdata_rx_in  input  1  serial receive line, asynchronous.
REQ-012 SHALL have port valid_rx_in  input  1  consumer acknowledge of received word.
REQ-013 SHALL have port ready_rx_out  output  1  received word available.
REQ-014 SHALL have port data_rx_out  output  BYTESIZES+4  received word: [BYTESIZES-1:0] data, [B] frame error, [B+1] parity error, [B+2] overrun, [B+3] break.

Function
REQ-015 SHALL generate a sample tick every DIV = COUNTER_CLOCK_INPUT/(BAUDRATE*OVERSAMPLING) clocks (integer, minimum 1); one bit period = OVERSAMPLING ticks for both TX and RX.
REQ-016 SHALL frame as: start bit 0, BYTESIZES data bits LSB first, optional parity bit (see Configuration), one stop bit 1.
REQ-017 TX SHALL use states IDLE, START, DATA, PARITY, STOP; IDLE drives sdata_tx_out=1 and ready_tx_out=1.
REQ-018 TX SHALL accept when valid_tx_in=1 and ready_tx_out=1 at a clock edge, latch data_tx_in, drop ready_tx_out and drive start bit from the next clock.
REQ-019 TX SHALL hold each bit exactly one bit period; after STOP completes it SHALL return to IDLE; valid_tx_in held high SHALL start the next frame on the cycle ready_tx_out returns high (back-to-back, no idle gap).
REQ-020 TX SHALL ignore data_tx_in changes while not in IDLE.
REQ-021 RX SHALL pass sdata_rx_in through a 2-flop synchronizer before any use.
REQ-022 RX SHALL use states IDLE, START, DATA, PARITY, STOP; IDLE leaves on synchronized 1->0 transition.
REQ-023 RX START SHALL wait OVERSAMPLING/2 ticks and resample; if line is 1 (glitch) SHALL return to IDLE without reporting.
REQ-024 RX SHALL then sample each subsequent bit every OVERSAMPLING ticks (bit centre), shifting data LSB first.
REQ-025 RX STOP sample 0 SHALL set frame error; 0 stop with all-zero data and parity SHALL also set break.
REQ-026 On STOP sample RX SHALL load data_rx_out, assert ready_rx_out next clock, return to IDLE; status bits zero on clean frame so data_rx_out equals the transmitted byte zero-extended.
REQ-027 ready_rx_out SHALL stay high, data_rx_out stable, until valid_rx_in=1 at a clock edge, which clears ready_rx_out next cycle.
REQ-028 If a frame completes while ready_rx_out=1 and not acknowledged that cycle, data SHALL be overwritten and overrun bit set; simultaneous completion and acknowledge SHALL load new word, ready stays 1, no overrun.
REQ-029 After a frame-error stop, RX SHALL wait for line 1 before rearming (no start detect during break).

Reset
REQ-030 nreset=0 at a clock edge SHALL force both FSMs to IDLE, sdata_tx_out=1, ready_tx_out=1, ready_rx_out=0, data_rx_out=0, tick counters and synchronizer (to 1) cleared, aborting any frame in progress.
REQ-031 Reset mid-frame SHALL produce no partial frame and no ready_rx_out pulse.

Configuration
REQ-032 With macro UART_PARITY_EN defined, an even-parity bit SHALL follow the data bits in TX and be checked by RX, mismatch setting bit [B+1].
REQ-033 Without UART_PARITY_EN, no parity bit SHALL be sent or expected and bit [B+1] SHALL be constant 0.

Verification
REQ-034 Reset: nreset=0 for 3 clocks -> sdata_tx_out=1, ready_tx_out=1, ready_rx_out=0, data_rx_out=0.
REQ-035 Loopback (sdata_tx_out->sdata_rx_in, COUNTER_CLOCK_INPUT=1_600_000, BAUDRATE=100_000, DIV=1) send 0x78 -> start bit 16 clocks, frame 160 clocks (176 with parity), data_rx_out=0x078, ready_rx_out=1.
REQ-036 Back-to-back 0xA5 then 0x3C with valid_tx_in held high and valid_rx_in=1 -> two words 0x0A5, 0x03C, no gap, no overrun.
REQ-037 Stop bit forced 0 on 0x55 -> data_rx_out=0x155 (frame error); all-zero line for one frame -> 0x900 (break+frame error).
REQ-038 Two frames with valid_rx_in=0 -> second word has bit [B+2] set (e.g. 0x4xx).
REQ-039 Start glitch of 4 clocks low, then nreset=0 mid-frame -> no ready_rx_out, sdata_tx_out=1 next clock after reset.
